dfd_trace_capture: RTL and testbench

Receiving end of the router DfD trigger/trace interface. Samples each cycle where trigger=1 and stores trace plus a timestamp into a circular capture buffer. A programmable match condition freezes the buffer after a fixed post-trigger window. A host then drains the buffer oldest-first over a valid/ready read port. One instance sits beside each router, or after an OR-merge of several routers, in the NoC debug fabric.

---
 rtl/dfd_trace_capture.sv | 153 +++++++++++++++
 tb/tb_dfd_trace_capture.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dfd_trace_capture.sv
// DfD trace capture: stamps router trace words into a circular buffer, freezes it
// a fixed number of entries after a programmable match, then drains oldest-first.
module dfd_trace_capture #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned TRACEw    = 32,
  parameter int unsigned TSw       = 16,
  parameter int unsigned POST_TRIG = 16,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic [TRACEw-1:0]     trace,
  input  logic                  arm,
  input  logic [TRACEw-1:0]     match_val,
  input  logic [TRACEw-1:0]     match_mask,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [TSw+TRACEw-1:0] rd_data,
  output logic [1:0]            state,
  output logic                  wrapped,
  output logic [AW:0]           entries
);

  localparam int unsigned DW = TSw + TRACEw;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [AW:0]   ENT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_LD  = AW'(POST_TRIG);
  localparam logic          HAS_POST = (POST_TRIG != 0);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] post_q, post_d;
  logic [AW:0]   entries_q, entries_d;
  logic          wrapped_q, wrapped_d;
  logic          rd_valid_q, rd_valid_d;
  logic [TSw-1:0] ts_q, ts_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic [DW-1:0] mem [DEPTH];

  logic          match_c;
  logic          wr_en_c;
  logic          xfer_c;
  logic [DW-1:0] wr_data_c;

  // Next-state, pointer, counter and read-port logic
  always_comb begin
    match_c   = trigger & ((trace & match_mask) == (match_val & match_mask));
    wr_en_c   = trigger & ~arm & ((state_q == ST_ARMED) | (state_q == ST_POST));
    xfer_c    = rd_valid_q & rd_ready & ~arm;
    wr_data_c = {ts_q, trace};

    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    post_d    = post_q;
    entries_d = entries_q;
    wrapped_d = wrapped_q;
    ts_d      = ts_q;
    rd_data_d = rd_data_q;

    if (arm) begin
      state_d   = ST_ARMED;
      wr_ptr_d  = '0;
      entries_d = '0;
      wrapped_d = 1'b0;
      ts_d      = '0;
      post_d    = '0;
    end else begin
      case (state_q)
        ST_ARMED, ST_POST: begin
          ts_d = ts_q + TSw'(1);
          if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (entries_q == ENT_FULL) wrapped_d = 1'b1;
            else                       entries_d = entries_q + (AW+1)'(1);
            if (state_q == ST_ARMED) begin
              if (match_c) begin
                post_d  = POST_LD;
                state_d = HAS_POST ? ST_POST : ST_DONE;
              end
            end else begin
              post_d = post_q - AW'(1);
              if (post_q == AW'(1)) state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (xfer_c) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            entries_d = entries_q - (AW+1)'(1);
            if (entries_q == (AW+1)'(1)) state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end

    // Oldest entry sits at wr_ptr once history has been overwritten
    if (!arm && (state_q != ST_DONE) && (state_d == ST_DONE))
      rd_ptr_d = wrapped_d ? wr_ptr_d : '0;

    rd_valid_d = (state_d == ST_DONE) && (entries_d != '0);

    // Forward the final write when it lands on the first entry to be read
    if (state_d == ST_DONE)
      rd_data_d = (wr_en_c && (wr_ptr_q == rd_ptr_d)) ? wr_data_c : mem[rd_ptr_d];
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      post_q     <= '0;
      entries_q  <= '0;
      wrapped_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      ts_q       <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      post_q     <= post_d;
      entries_q  <= entries_d;
      wrapped_q  <= wrapped_d;
      rd_valid_q <= rd_valid_d;
      ts_q       <= ts_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Capture storage; contents need no reset
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr_q] <= wr_data_c;
  end

  assign state    = state_q;
  assign entries  = entries_q;
  assign wrapped  = wrapped_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_dfd_trace_capture.sv
// Bench for dfd_trace_capture: three instances (POST_TRIG 0, 2, 3) share stimulus;
// a directed vector table plus hand-written multi-cycle sequences.
module tb_dfd_trace_capture;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TW    = 32;
  localparam int unsigned SW    = 16;
  localparam int unsigned DW    = SW + TW;

  logic          clk = 1'b0;
  logic          reset;
  logic          arm, trigger, rd_ready;
  logic [TW-1:0] trace, match_val, match_mask;

  // index 0: POST_TRIG=0, 1: POST_TRIG=2, 2: POST_TRIG=3
  logic          rd_valid [3];
  logic [DW-1:0] rd_data  [3];
  logic [1:0]    st       [3];
  logic          wrapped  [3];
  logic [3:0]    ent      [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dfd_trace_capture #(.DEPTH(DEPTH), .TRACEw(TW), .TSw(SW), .POST_TRIG(0)) u_pt0 (
    .clk(clk), .reset(reset), .trigger(trigger), .trace(trace), .arm(arm),
    .match_val(match_val), .match_mask(match_mask), .rd_valid(rd_valid[0]),
    .rd_ready(rd_ready), .rd_data(rd_data[0]), .state(st[0]), .wrapped(wrapped[0]),
    .entries(ent[0]));

  dfd_trace_capture #(.DEPTH(DEPTH), .TRACEw(TW), .TSw(SW), .POST_TRIG(2)) u_pt2 (
    .clk(clk), .reset(reset), .trigger(trigger), .trace(trace), .arm(arm),
    .match_val(match_val), .match_mask(match_mask), .rd_valid(rd_valid[1]),
    .rd_ready(rd_ready), .rd_data(rd_data[1]), .state(st[1]), .wrapped(wrapped[1]),
    .entries(ent[1]));

  dfd_trace_capture #(.DEPTH(DEPTH), .TRACEw(TW), .TSw(SW), .POST_TRIG(3)) u_pt3 (
    .clk(clk), .reset(reset), .trigger(trigger), .trace(trace), .arm(arm),
    .match_val(match_val), .match_mask(match_mask), .rd_valid(rd_valid[2]),
    .rd_ready(rd_ready), .rd_data(rd_data[2]), .state(st[2]), .wrapped(wrapped[2]),
    .entries(ent[2]));

  typedef struct {
    logic          arm;
    logic          trig;
    logic [TW-1:0] tr;
    logic          rr;
    logic [1:0]    st;
    logic [3:0]    ent;
    logic          wr;
    logic          vld;
    logic          chk_d;
    logic [DW-1:0] d;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_ctl(input int u, input string nm, input logic [1:0] es,
                         input logic [3:0] ee, input logic ew, input logic ev);
    chk({nm, ".state"},    64'(st[u]),       64'(es));
    chk({nm, ".entries"},  64'(ent[u]),      64'(ee));
    chk({nm, ".wrapped"},  64'(wrapped[u]),  64'(ew));
    chk({nm, ".rd_valid"}, 64'(rd_valid[u]), 64'(ev));
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge
  task automatic step(input logic a, input logic t, input logic [TW-1:0] tr, input logic rr);
    arm      = a;
    trigger  = t;
    trace    = tr;
    rd_ready = rr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] ent_of(input int ts, input logic [TW-1:0] tr);
    return {SW'(ts), tr};
  endfunction

  logic [TW-1:0] wrap_tr [8];
  int            wrap_ts [8];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 2'd1, 4'd0, 1'b0, 1'b0, 1'b0, '0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 2'd1, 4'd0, 1'b0, 1'b0, 1'b0, '0};
    tbl[2]  = '{1'b0, 1'b1, 32'h1,  1'b0, 2'd1, 4'd1, 1'b0, 1'b0, 1'b0, '0};
    tbl[3]  = '{1'b0, 1'b1, 32'h2,  1'b0, 2'd1, 4'd2, 1'b0, 1'b0, 1'b0, '0};
    tbl[4]  = '{1'b0, 1'b1, 32'hA5, 1'b0, 2'd2, 4'd3, 1'b0, 1'b0, 1'b0, '0};
    tbl[5]  = '{1'b0, 1'b1, 32'h3,  1'b0, 2'd2, 4'd4, 1'b0, 1'b0, 1'b0, '0};
    tbl[6]  = '{1'b0, 1'b1, 32'h4,  1'b0, 2'd3, 4'd5, 1'b0, 1'b1, 1'b1, 48'h0001_00000001};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd3, 4'd4, 1'b0, 1'b1, 1'b1, 48'h0002_00000002};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd3, 4'd3, 1'b0, 1'b1, 1'b1, 48'h0003_000000A5};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd3, 4'd2, 1'b0, 1'b1, 1'b1, 48'h0004_00000003};
    tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd3, 4'd1, 1'b0, 1'b1, 1'b1, 48'h0005_00000004};
    tbl[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, '0};

    wrap_tr = '{32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'hA5, 32'h10, 32'h11};
    wrap_ts = '{5, 6, 7, 8, 9, 10, 11, 12};

    reset = 1'b1; arm = 1'b0; trigger = 1'b0; trace = '0; rd_ready = 1'b0;
    match_val = 32'hA5; match_mask = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk_ctl(u, $sformatf("reset[%0d]", u), 2'd0, 4'd0, 1'b0, 1'b0);
      chk($sformatf("reset[%0d].rd_data", u), 64'(rd_data[u]), 64'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    #2;

    // Basic capture and drain on the POST_TRIG=2 instance
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].arm, tbl[i].trig, tbl[i].tr, tbl[i].rr);
      chk_ctl(1, $sformatf("basic[%0d]", i), tbl[i].st, tbl[i].ent, tbl[i].wr, tbl[i].vld);
      if (tbl[i].chk_d)
        chk($sformatf("basic[%0d].rd_data", i), 64'(rd_data[1]), 64'(tbl[i].d));
    end

    // Wrap: 10 pre-match writes, match, two post writes
    step(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, TW'(k), 1'b0);
    step(1'b0, 1'b1, 32'hA5, 1'b0);
    step(1'b0, 1'b1, 32'h10, 1'b0);
    step(1'b0, 1'b1, 32'h11, 1'b0);
    chk_ctl(1, "wrap.done", 2'd3, 4'd8, 1'b1, 1'b1);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("wrap.rd[%0d]", j), 64'(rd_data[1]), 64'(ent_of(wrap_ts[j], wrap_tr[j])));
      step(1'b0, 1'b0, '0, 1'b1);
    end
    chk_ctl(1, "wrap.idle", 2'd0, 4'd0, 1'b1, 1'b0);

    // Gapped post-trigger writes on the POST_TRIG=3 instance, then backpressure
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h1, 1'b0);
    step(1'b0, 1'b1, 32'hA5, 1'b0);
    chk("gap.post", 64'(st[2]), 64'd2);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h20, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h21, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk_ctl(2, "gap.still_post", 2'd2, 4'd4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h22, 1'b0);
    chk_ctl(2, "gap.done", 2'd3, 4'd5, 1'b0, 1'b1);
    for (int s = 0; s < 5; s++) begin
      step(1'b0, 1'b0, '0, 1'b0);
      chk($sformatf("stall[%0d].rd_valid", s), 64'(rd_valid[2]), 64'd1);
      chk($sformatf("stall[%0d].rd_data", s), 64'(rd_data[2]), 64'(ent_of(0, 32'h1)));
    end
    step(1'b0, 1'b0, '0, 1'b1);
    chk("gap.xfer.entries", 64'(ent[2]), 64'd4);
    chk("gap.xfer.rd_data", 64'(rd_data[2]), 64'(ent_of(1, 32'hA5)));
    // Abort during readout with rd_ready asserted
    step(1'b1, 1'b0, '0, 1'b1);
    chk_ctl(2, "abort_rd", 2'd1, 4'd0, 1'b0, 1'b0);

    // POST_TRIG=0 with a zero mask: first trigger completes capture
    match_mask = '0;
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h77, 1'b0);
    chk_ctl(0, "pt0", 2'd3, 4'd1, 1'b0, 1'b1);
    chk("pt0.trace", 64'(rd_data[0][TW-1:0]), 64'h77);
    chk("pt0.rd_data", 64'(rd_data[0]), 64'(ent_of(0, 32'h77)));
    chk("abort_post.pre", 64'(st[1]), 64'd2);
    step(1'b1, 1'b0, '0, 1'b0);
    chk_ctl(1, "abort_post", 2'd1, 4'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-readout
    step(1'b0, 1'b1, 32'h30, 1'b0);
    step(1'b0, 1'b1, 32'h31, 1'b0);
    step(1'b0, 1'b1, 32'h32, 1'b0);
    step(1'b0, 1'b1, 32'h33, 1'b0);
    chk_ctl(2, "rst.pre", 2'd3, 4'd4, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("rst.pre.entries", 64'(ent[2]), 64'd3);
    rd_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk_ctl(2, "rst.async", 2'd0, 4'd0, 1'b0, 1'b0);
    chk("rst.async.rd_data", 64'(rd_data[2]), 64'h0);
    #1 reset = 1'b0;
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h99, 1'b0);
    chk_ctl(0, "rst.recap", 2'd3, 4'd1, 1'b0, 1'b1);
    chk("rst.recap.rd_data", 64'(rd_data[0]), 64'(ent_of(0, 32'h99)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
